piradip_fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter sharing one `piradip_sync_fifo` instance between N_REQ stream producers. Each producer presents valid/ready/data/last beats; the arbiter grants one producer at a time, drives the FIFO `we`/`din`, and tags every entry with the source ID and last flag so the consumer can demultiplexe packets. It sits directly in front of the FIFO write port and never writes while the FIFO is `full` or `wr_rst_busy`.

---
 rtl/piradip_fifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_piradip_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piradip_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : piradip_fifo_wr_arbiter
// Description : Round-robin write-side arbiter that lets N_REQ stream
//               producers share one piradip_sync_fifo write port. Each FIFO
//               entry is tagged {source id, last, data}. No write is issued
//               while the FIFO is full or in write reset.
//               Build option PIRADIP_FIFO_ARB_PKT_LOCK_EN: when defined, a
//               grant is held for a whole packet (up to the beat with last=1);
//               when undefined, the grant rotates after every beat.
// Revision    : 1.0 - initial release
// ============================================================================
module piradip_fifo_wr_arbiter #(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int FIFO_WIDTH = DATA_WIDTH + 1 + ID_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            s_valid,
  output logic [N_REQ-1:0]            s_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [N_REQ-1:0]            s_last,
  output logic                        fifo_we,
  output logic [FIFO_WIDTH-1:0]       fifo_din,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_rst_busy,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [15:0]                 pkt_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [ID_WIDTH-1:0] c_last_id = ID_WIDTH'(N_REQ - 1);
  localparam logic [ID_WIDTH:0]   c_n_req   = (ID_WIDTH + 1)'(N_REQ);
  localparam logic [N_REQ-1:0]    c_one     = N_REQ'(1);

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [ID_WIDTH-1:0] r_gid;
  logic [ID_WIDTH-1:0] r_rr;
  logic                r_in_tenure;
  logic [15:0]         r_pkt_count;

  logic                w_granted;
  logic                w_fifo_ok;
  logic                w_g_valid;
  logic                w_g_last;
  logic                w_xfer;
  logic                w_tenure_done;
  logic                w_abandon;
  logic                w_handover;
  logic                w_any;
  logic [ID_WIDTH-1:0] w_gid_next;
  logic [ID_WIDTH-1:0] w_start;
  logic [2*N_REQ-1:0]  w_dbl;
  logic [N_REQ-1:0]    w_rot;
  logic [ID_WIDTH-1:0] w_off;
  logic [ID_WIDTH:0]   w_sum;
  logic [ID_WIDTH-1:0] w_win;

  assign w_granted  = (r_state == ST_GRANT);
  assign w_fifo_ok  = !fifo_full && !fifo_wr_rst_busy;
  assign w_g_valid  = s_valid[r_gid];
  assign w_g_last   = s_last[r_gid];
  assign w_xfer     = w_granted && w_g_valid && w_fifo_ok;
  assign w_any      = |s_valid;
  assign w_gid_next = (r_gid == c_last_id) ? '0 : r_gid + 1'b1;

`ifdef PIRADIP_FIFO_ARB_PKT_LOCK_EN
  assign w_tenure_done = w_xfer && w_g_last;
`else
  assign w_tenure_done = w_xfer;
`endif

  // A granted source that drops valid before sending any beat of its tenure
  // gives the grant up; once a packet is under way the grant is held.
  assign w_abandon  = w_granted && !w_g_valid && !r_in_tenure;
  assign w_handover = w_tenure_done || w_abandon;

  // Search starts after the current holder on handover, at rr pointer in IDLE.
  // Starting at g+1 and scanning N_REQ slots naturally reaches g last, so g
  // only wins again when it is the sole requester.
  assign w_start = w_granted ? w_gid_next : r_rr;
  assign w_dbl   = {s_valid, s_valid};
  assign w_rot   = w_dbl[w_start +: N_REQ];

  // Priority encode the rotated request vector: lowest offset wins.
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_WIDTH'(k);
    end
  end

  assign w_sum = {1'b0, w_start} + {1'b0, w_off};
  assign w_win = (w_sum >= c_n_req) ? ID_WIDTH'(w_sum - c_n_req) : w_sum[ID_WIDTH-1:0];

  // Arbitration state, grant, round-robin pointer and packet counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_gid       <= '0;
      r_rr        <= '0;
      r_in_tenure <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (w_xfer && w_g_last) r_pkt_count <= r_pkt_count + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_grant <= c_one << w_win;
            r_gid   <= w_win;
          end
        end
        ST_GRANT: begin
          if (w_xfer) r_in_tenure <= !w_tenure_done;
          if (w_handover) begin
            r_rr        <= w_gid_next;
            r_in_tenure <= 1'b0;
            if (w_any) begin
              r_grant <= c_one << w_win;
              r_gid   <= w_win;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= '0;
              r_gid   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign s_ready   = w_fifo_ok ? r_grant : '0;
  assign fifo_we   = w_xfer;
  assign fifo_din  = w_granted ? {r_gid, w_g_last, s_data[r_gid*DATA_WIDTH +: DATA_WIDTH]} : '0;
  assign grant     = r_grant;
  assign busy      = w_granted;
  assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_piradip_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_piradip_fifo_wr_arbiter
// Description : Directed self-checking bench for piradip_fifo_wr_arbiter.
//               Expected FIFO contents follow the build option
//               PIRADIP_FIFO_ARB_PKT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piradip_fifo_wr_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 2;
  localparam int FIFO_WIDTH = DATA_WIDTH + 1 + ID_WIDTH;

  logic                        clk = 1'b0;
  logic                        rstn;
  logic [N_REQ-1:0]            s_valid;
  logic [N_REQ-1:0]            s_ready;
  logic [N_REQ*DATA_WIDTH-1:0] s_data;
  logic [N_REQ-1:0]            s_last;
  logic                        fifo_we;
  logic [FIFO_WIDTH-1:0]       fifo_din;
  logic                        fifo_full;
  logic                        fifo_wr_rst_busy;
  logic [N_REQ-1:0]            grant;
  logic                        busy;
  logic [15:0]                 pkt_count;

  piradip_fifo_wr_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .s_last           (s_last),
    .fifo_we          (fifo_we),
    .fifo_din         (fifo_din),
    .fifo_full        (fifo_full),
    .fifo_wr_rst_busy (fifo_wr_rst_busy),
    .grant            (grant),
    .busy             (busy),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DATA_WIDTH:0]   src_q [N_REQ][$];
  logic [FIFO_WIDTH-1:0] wlog[$];
  int                    wcyc[$];
  logic                  smp_we;
  logic [N_REQ-1:0]      smp_ready;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] dv(input int src, input int beat);
    return 32'hC0DE_0000 + 32'(src) * 32'd256 + 32'(beat);
  endfunction

  function automatic logic [FIFO_WIDTH-1:0] mk(input int id, input logic last, input logic [DATA_WIDTH-1:0] d);
    return {ID_WIDTH'(id), last, d};
  endfunction

  task automatic push_pkt(input int src, input int nbeats);
    for (int b = 0; b < nbeats; b++) src_q[src].push_back({(b == nbeats - 1), dv(src, b)});
  endtask

  task automatic apply_drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i] = 1'b1;
        s_last[i]  = src_q[i][0][DATA_WIDTH];
        s_data[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0][DATA_WIDTH-1:0];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        s_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endtask

  // One clock: drive producers, sample at the falling edge, retire accepted beats.
  task automatic cycle();
    logic [N_REQ-1:0] acc;
    apply_drive();
    @(negedge clk);
    check_eq("we_matches_handshake", fifo_we, |(s_valid & s_ready));
    check_eq("no_write_when_blocked", fifo_we & (fifo_full | fifo_wr_rst_busy), 0);
    check_eq("ready_only_to_grant", s_ready & ~grant, 0);
    if (fifo_we) begin
      wlog.push_back(fifo_din);
      wcyc.push_back(cyc);
    end
    acc       = s_valid & s_ready;
    smp_we    = fifo_we;
    smp_ready = s_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int exp_id[6];
    int exp_bt[6];

    rstn             = 1'b0;
    s_valid          = '1;
    s_data           = '0;
    s_last           = '0;
    fifo_full        = 1'b0;
    fifo_wr_rst_busy = 1'b0;

    // Reset with every requester asking
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_ready", s_ready, 0);
    check_eq("rst_we", fifo_we, 0);
    check_eq("rst_din", fifo_din, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    s_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Two simultaneous 3-beat packets from requesters 0 and 2
`ifdef PIRADIP_FIFO_ARB_PKT_LOCK_EN
    exp_id = '{0, 0, 0, 2, 2, 2};
    exp_bt = '{0, 1, 2, 0, 1, 2};
`else
    exp_id = '{0, 2, 0, 2, 0, 2};
    exp_bt = '{0, 0, 1, 1, 2, 2};
`endif
    push_pkt(0, 3);
    push_pkt(2, 3);
    wlog.delete();
    wcyc.delete();
    t0 = cyc;
    for (int g = 0; g < 20 && wlog.size() < 6; g++) cycle();
    check_eq("pair_write_count", wlog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < wlog.size())
        check_eq($sformatf("pair_entry%0d", k), wlog[k], mk(exp_id[k], exp_bt[k] == 2, dv(exp_id[k], exp_bt[k])));
    end
    if (wlog.size() > 0) check_eq("pair_first_latency", wcyc[0] - t0, 1);
    if (wlog.size() == 6) check_eq("pair_no_gap", wcyc[5] - wcyc[0], 5);
    repeat (2) cycle();
    check_eq("pair_pkt_count", pkt_count, 2);
    check_eq("pair_back_to_idle", busy, 0);

    // FIFO full for 4 cycles (then write-reset busy for 1) mid-packet
    push_pkt(1, 6);
    wlog.delete();
    wcyc.delete();
    for (int g = 0; g < 10 && wlog.size() < 2; g++) cycle();
    fifo_full = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cycle();
      check_eq($sformatf("full_ready_c%0d", j), smp_ready, 0);
      check_eq($sformatf("full_we_c%0d", j), smp_we, 0);
    end
    fifo_full        = 1'b0;
    fifo_wr_rst_busy = 1'b1;
    cycle();
    check_eq("wrrst_ready", smp_ready, 0);
    check_eq("wrrst_we", smp_we, 0);
    fifo_wr_rst_busy = 1'b0;
    for (int g = 0; g < 20 && wlog.size() < 6; g++) cycle();
    check_eq("full_write_count", wlog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < wlog.size()) check_eq($sformatf("full_entry%0d", k), wlog[k], mk(1, k == 5, dv(1, k)));
    end
    repeat (2) cycle();
    check_eq("full_pkt_count", pkt_count, 3);

    // Reset asserted while beat 2 of a 4-beat packet is on the bus
    push_pkt(1, 4);
    wlog.delete();
    wcyc.delete();
    for (int g = 0; g < 10 && wlog.size() < 1; g++) cycle();
    apply_drive();
    #1;
    check_eq("midrst_beat2_writing", fifo_we, 1);
    rstn = 1'b0;
    #1;
    check_eq("midrst_we", fifo_we, 0);
    check_eq("midrst_grant", grant, 0);
    check_eq("midrst_ready", s_ready, 0);
    check_eq("midrst_busy", busy, 0);
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    apply_drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("midrst_pkt_count", pkt_count, 0);
    rstn = 1'b1;

    // Fairness: all requesters continuously valid with 1-beat packets
    for (int i = 0; i < N_REQ; i++)
      for (int b = 0; b < 4; b++) src_q[i].push_back({1'b1, dv(i, b)});
    wlog.delete();
    wcyc.delete();
    t0 = cyc;
    for (int g = 0; g < 40 && wlog.size() < 16; g++) cycle();
    check_eq("fair_write_count", wlog.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < wlog.size()) check_eq($sformatf("fair_entry%0d", k), wlog[k], mk(k % 4, 1'b1, dv(k % 4, k / 4)));
    end
    if (wlog.size() > 0) check_eq("fair_first_latency", wcyc[0] - t0, 1);
    if (wlog.size() == 16) check_eq("fair_no_gap", wcyc[15] - wcyc[0], 15);
    repeat (2) cycle();
    check_eq("fair_pkt_count", pkt_count, 16);
    check_eq("fair_back_to_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
